// File: rtl/wormhole_concentrator.sv
// rtl/wormhole_concentrator.sv - concentrates num_in_p wormhole links onto one router link and back
// Each input is buffered in a 2-entry FIFO; both directions run independently.

module wormhole_concentrator_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               enq;

    assign ready_o = (count != 2'd2);
    assign v_o     = (count != 2'd0);
    assign data_o  = mem[rd_ptr];
    assign enq     = v_i && ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (yumi_i) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, enq} - {1'b0, yumi_i};
        end
    end
endmodule

module wormhole_concentrator #(
    parameter int flit_width_p = 32,
    parameter int num_in_p     = 3,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_in_p-1:0][flit_width_p+1:0]  links_i,
    output logic [num_in_p-1:0][flit_width_p+1:0]  links_o,
    input  logic [flit_width_p+1:0]                concentrated_link_i,
    output logic [flit_width_p+1:0]                concentrated_link_o
);
    localparam int len_lsb_lp = cord_width_p;
    localparam int cid_lsb_lp = cord_width_p + len_width_p;
    localparam int v_bit_lp   = flit_width_p + 1;

    logic [num_in_p-1:0]     in_v;
    logic [num_in_p-1:0]     in_ready;
    logic [num_in_p-1:0]     in_yumi;
    logic [flit_width_p-1:0] in_data [num_in_p];

    logic                    c_v;
    logic                    c_ready;
    logic                    c_yumi;
    logic [flit_width_p-1:0] c_data;

    // concentrate-direction state
    logic [cid_width_p-1:0]  rr_ptr;
    logic [cid_width_p-1:0]  grant;
    logic [cid_width_p-1:0]  owner;
    logic [cid_width_p-1:0]  sel;
    logic [cid_width_p:0]    rr_idx;
    logic                    any_v;
    logic                    locked;
    logic                    hdr_phase;
    logic [len_width_p-1:0]  c_rem;
    logic                    c_out_v;
    logic [flit_width_p-1:0] c_out_data;
    logic                    c_hs;
    logic                    c_is_hdr;
    logic [len_width_p-1:0]  c_hdr_len;

    // deconcentrate-direction state
    logic                    d_active;
    logic                    d_drop;
    logic [cid_width_p-1:0]  d_cid;
    logic [len_width_p-1:0]  d_rem;
    logic [cid_width_p-1:0]  hdr_cid;
    logic [len_width_p-1:0]  d_hdr_len;
    logic [cid_width_p-1:0]  d_sel;
    logic                    d_sel_drop;
    logic                    d_out_v;
    logic                    d_hs;

    for (genvar k = 0; k < num_in_p; k++) begin : g_link
        wormhole_concentrator_fifo #(.width_p(flit_width_p)) in_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (links_i[k][flit_width_p:1]),
            .v_i     (links_i[k][v_bit_lp]),
            .ready_o (in_ready[k]),
            .data_o  (in_data[k]),
            .v_o     (in_v[k]),
            .yumi_i  (in_yumi[k])
        );
        assign in_yumi[k] = c_hs && (sel == cid_width_p'(k));
        assign links_o[k] = {d_out_v && (d_sel == cid_width_p'(k)), c_data, in_ready[k] && !reset_i};
    end

    wormhole_concentrator_fifo #(.width_p(flit_width_p)) conc_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (concentrated_link_i[flit_width_p:1]),
        .v_i     (concentrated_link_i[v_bit_lp]),
        .ready_o (c_ready),
        .data_o  (c_data),
        .v_o     (c_v),
        .yumi_i  (c_yumi)
    );

    // Lowest offset from rr_ptr wins; the loop runs high-to-low so it is assigned last.
    always_comb begin
        grant  = '0;
        any_v  = 1'b0;
        rr_idx = '0;
        for (int i = num_in_p - 1; i >= 0; i--) begin
            rr_idx = {1'b0, rr_ptr} + (cid_width_p + 1)'(i);
            if (rr_idx >= (cid_width_p + 1)'(num_in_p)) begin
                rr_idx = rr_idx - (cid_width_p + 1)'(num_in_p);
            end
            if (in_v[rr_idx[cid_width_p-1:0]]) begin
                grant = rr_idx[cid_width_p-1:0];
                any_v = 1'b1;
            end
        end
    end

    assign sel        = locked ? owner : grant;
    assign c_out_v    = locked ? in_v[owner] : any_v;
    assign c_out_data = in_data[sel];
    assign c_hs       = c_out_v && concentrated_link_i[0];
    assign c_is_hdr   = !locked || hdr_phase;
    assign c_hdr_len  = c_out_data[len_lsb_lp +: len_width_p];

    assign concentrated_link_o = {c_out_v, c_out_data, c_ready && !reset_i};

    // A header presented but not accepted locks the winner so the output stays stable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr    <= '0;
            owner     <= '0;
            locked    <= 1'b0;
            hdr_phase <= 1'b0;
            c_rem     <= '0;
        end else if (c_hs) begin
            if (c_is_hdr) begin
                rr_ptr    <= (sel == cid_width_p'(num_in_p - 1)) ? '0 : sel + 1'b1;
                owner     <= sel;
                hdr_phase <= 1'b0;
                c_rem     <= c_hdr_len;
                locked    <= (c_hdr_len != '0);
            end else begin
                c_rem  <= c_rem - 1'b1;
                locked <= (c_rem != len_width_p'(1));
            end
        end else if (!locked && any_v) begin
            locked    <= 1'b1;
            owner     <= grant;
            hdr_phase <= 1'b1;
        end
    end

    assign hdr_cid    = c_data[cid_lsb_lp +: cid_width_p];
    assign d_hdr_len  = c_data[len_lsb_lp +: len_width_p];
    assign d_sel      = d_active ? d_cid : hdr_cid;
    assign d_sel_drop = d_active ? d_drop : ({1'b0, hdr_cid} >= (cid_width_p + 1)'(num_in_p));
    assign d_out_v    = c_v && !d_sel_drop;
    assign d_hs       = c_v && (d_sel_drop || links_i[d_sel][0]);
    assign c_yumi     = d_hs;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            d_active <= 1'b0;
            d_drop   <= 1'b0;
            d_cid    <= '0;
            d_rem    <= '0;
        end else if (d_hs) begin
            if (!d_active) begin
                d_active <= (d_hdr_len != '0);
                d_cid    <= hdr_cid;
                d_drop   <= d_sel_drop;
                d_rem    <= d_hdr_len;
            end else begin
                d_rem    <= d_rem - 1'b1;
                d_active <= (d_rem != len_width_p'(1));
            end
        end
    end
endmodule

// File: tb/tb_wormhole_concentrator.sv
// tb/tb_wormhole_concentrator.sv - randomized queue-model bench for wormhole_concentrator
module tb_wormhole_concentrator;
    localparam int fw = 32;
    localparam int n  = 3;
    localparam int vb = fw + 1;

    logic                 clk     = 1'b0;
    logic                 reset_i = 1'b1;
    logic [n-1:0][fw+1:0] links_i = '0;
    logic [n-1:0][fw+1:0] links_o;
    logic [fw+1:0]        conc_i  = '0;
    logic [fw+1:0]        conc_o;

    always #5 clk = ~clk;

    wormhole_concentrator #(
        .flit_width_p (fw),
        .num_in_p     (n),
        .cord_width_p (8),
        .len_width_p  (4)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .links_i             (links_i),
        .links_o             (links_o),
        .concentrated_link_i (conc_i),
        .concentrated_link_o (conc_o)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] src_q [n][$];
    logic [31:0] csrc_q[$];
    logic [31:0] exp_c [n][$];
    logic [31:0] exp_d [n][$];
    logic [3:0]  hdr_order[$];

    int   cyc = 0;
    int   rdy_pct = 100;
    int   gap_pct = 0;
    bit   tog1 = 1'b0;
    int   first_in, first_out, last_out, out_c;
    int   vcnt[n];
    bit   saw_full;
    int   c_rem = 0;
    logic [3:0] c_src = '0;
    int   sent_flits = 0;
    int   recv_flits = 0;
    int   seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // header: {tag[3:0], seq[13:0], cid[1:0], len[3:0], cord[7:0]}; body: {tag, random}
    task automatic send_node(input int k, input int len, input int cid);
        logic [31:0] f;
        f = {4'(k), 14'(seq), 2'(cid), 4'(len), 8'($urandom)};
        seq++;
        src_q[k].push_back(f);
        exp_c[k].push_back(f);
        sent_flits++;
        for (int i = 0; i < len; i++) begin
            f = {4'(k), 28'($urandom)};
            src_q[k].push_back(f);
            exp_c[k].push_back(f);
            sent_flits++;
        end
    endtask

    task automatic send_conc(input int len, input int cid);
        logic [31:0] f;
        for (int i = 0; i <= len; i++) begin
            f = (i == 0) ? {4'hC, 14'(seq), 2'(cid), 4'(len), 8'($urandom)} : {4'hC, 28'($urandom)};
            csrc_q.push_back(f);
            if (cid < n) begin
                exp_d[cid].push_back(f);
                sent_flits++;
            end
        end
        seq++;
    endtask

    task automatic mon_conc(input logic [31:0] d);
        int s;
        bit avail;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_c++;
        recv_flits++;
        if (c_rem == 0) begin
            c_src = d[31:28];
            hdr_order.push_back(d[31:28]);
            c_rem = int'(d[11:8]);
        end else begin
            check("conc_no_interleave", d[31:28], c_src);
            c_rem--;
        end
        s = int'(d[31:28]);
        avail = (s < n) ? (exp_c[s].size() > 0) : 1'b0;
        check("conc_expected", avail, 1'b1);
        if (avail) check("conc_flit", d, exp_c[s].pop_front());
    endtask

    task automatic mon_deconc(input int k, input logic [31:0] d);
        bit avail;
        recv_flits++;
        avail = (exp_d[k].size() > 0);
        check("deconc_expected", avail, 1'b1);
        if (avail) check("deconc_flit", d, exp_d[k].pop_front());
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset_i) return;
        conc_i[0] = ($urandom_range(99) < rdy_pct);
        for (int k = 0; k < n; k++)
            links_i[k][0] = (tog1 && k == 1) ? ((cyc % 2) == 1) : ($urandom_range(99) < rdy_pct);
        if (!conc_o[0]) saw_full = 1'b1;
        if (conc_o[vb] && conc_i[0]) mon_conc(conc_o[fw:1]);
        for (int k = 0; k < n; k++) begin
            if (links_o[k][vb]) begin
                vcnt[k]++;
                if (links_i[k][0]) mon_deconc(k, links_o[k][fw:1]);
            end
        end
        for (int k = 0; k < n; k++) begin
            links_i[k][vb]   = (src_q[k].size() > 0) && ($urandom_range(99) >= gap_pct);
            links_i[k][fw:1] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
            if (links_i[k][vb] && links_o[k][0]) begin
                void'(src_q[k].pop_front());
                if (first_in < 0) first_in = cyc;
            end
        end
        conc_i[vb]   = (csrc_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        conc_i[fw:1] = (csrc_q.size() > 0) ? csrc_q[0] : '0;
        if (conc_i[vb] && conc_o[0]) void'(csrc_q.pop_front());
    endtask

    function automatic bit idle();
        bit r = (csrc_q.size() == 0);
        for (int k = 0; k < n; k++)
            r &= (src_q[k].size() == 0) && (exp_c[k].size() == 0) && (exp_d[k].size() == 0);
        return r;
    endfunction

    task automatic drain(input string tag, input int budget);
        int i = 0;
        while (!idle() && i < budget) begin
            step();
            i++;
        end
        check({tag, "_drained"}, idle(), 1'b1);
        repeat (4) step();
    endtask

    task automatic reset_stats();
        first_in  = -1;
        first_out = -1;
        last_out  = -1;
        out_c     = 0;
        saw_full  = 1'b0;
        hdr_order.delete();
        for (int k = 0; k < n; k++) vcnt[k] = 0;
    endtask

    task automatic clear_model();
        csrc_q.delete();
        for (int k = 0; k < n; k++) begin
            src_q[k].delete();
            exp_c[k].delete();
            exp_d[k].delete();
        end
        c_rem = 0;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_conc_v"}, conc_o[vb], 1'b0);
        check({tag, "_conc_ready"}, conc_o[0], 1'b0);
        for (int k = 0; k < n; k++) begin
            check({tag, "_link_v"}, links_o[k][vb], 1'b0);
            check({tag, "_link_ready"}, links_o[k][0], 1'b0);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        links_i = '0;
        conc_i  = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_all_low("rst");
        reset_i = 1'b0;
    endtask

    initial begin
        reset_stats();
        do_reset();

        // single node burst, latency and return path to cid 2
        reset_stats();
        send_node(0, 3, 0);
        drain("t1", 50);
        check("t1_latency", first_out - first_in, 1);
        check("t1_burst_span", last_out - first_out, 3);
        check("t1_count", out_c, 4);
        reset_stats();
        send_conc(2, 2);
        drain("t1r", 50);
        check("t1r_v_link2", vcnt[2], 3);
        check("t1r_v_others", vcnt[0] + vcnt[1], 0);

        // simultaneous packets from all nodes, twice, order must restart at node0
        do_reset();
        reset_stats();
        for (int k = 0; k < n; k++) send_node(k, 2, 0);
        drain("t3a", 100);
        for (int k = 0; k < n; k++) send_node(k, 2, 0);
        drain("t3b", 100);
        check("rr_count", hdr_order.size(), 6);
        for (int i = 0; i < hdr_order.size() && i < 6; i++) check("rr_order", hdr_order[i], i % 3);

        // congestion into node1 with toggling ready
        reset_stats();
        tog1 = 1'b1;
        for (int p = 0; p < 4; p++) send_conc(5, 1);
        drain("t4", 300);
        tog1 = 1'b0;
        check("t4_backpressure", saw_full, 1'b1);
        check("t4_v_others", vcnt[0] + vcnt[2], 0);

        // back-to-back header-only packets from node2
        reset_stats();
        for (int p = 0; p < 6; p++) send_node(2, 0, 0);
        drain("t5", 50);
        check("t5_count", out_c, 6);
        check("t5_span", last_out - first_out, 5);

        // out-of-range cid is dropped, next packet delivered
        reset_stats();
        send_conc(2, 3);
        send_conc(1, 0);
        drain("t6", 50);
        check("t6_v_total", vcnt[0] + vcnt[1] + vcnt[2], 2);
        check("t6_v_link0", vcnt[0], 2);

        // asynchronous reset mid-packet
        rdy_pct = 0;
        send_node(1, 4, 0);
        send_conc(3, 1);
        repeat (4) step();
        @(posedge clk);
        #2 reset_i = 1'b1;
        #1 check_all_low("async_rst");
        clear_model();
        links_i = '0;
        conc_i  = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        rdy_pct = 100;
        reset_stats();
        send_node(1, 3, 0);
        drain("t7", 50);
        check("t7_count", out_c, 4);

        // random run, 1000 packets across both directions
        rdy_pct    = 70;
        gap_pct    = 30;
        sent_flits = 0;
        recv_flits = 0;
        for (int p = 0; p < 1000; p++) begin
            if (p % 4 == 3) send_conc($urandom_range(7), $urandom_range(3));
            else send_node(p % 4, $urandom_range(7), $urandom_range(3));
        end
        drain("t8", 60000);
        check("t8_flit_counts", recv_flits, sent_flits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
